// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per cycle with registered frame, done and busy flags.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             last_bit;
    logic             accept;

    // shreg holds only the bits still to be sent; the bit on the wire lives in sdata_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;

        last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;

        if (accept) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            sframe_d = 1'b1;
            busy_d   = 1'b1;
            if (MSB_FIRST != 0) begin
                sdata_d = data_in[WIDTH-1];
                shreg_d = {data_in[WIDTH-2:0], 1'b0};
            end else begin
                sdata_d = data_in[0];
                shreg_d = {1'b0, data_in[WIDTH-1:1]};
            end
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                sframe_d = 1'b1;
                busy_d   = 1'b1;
                done_d   = ((cnt_q + CW'(1)) == LAST);
                if (MSB_FIRST != 0) begin
                    sdata_d = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    sdata_d = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign sdata  = sdata_q;
    assign sframe = sframe_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance, checked with
// immediate assertions at the falling edge after each rising edge.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic       lv_a, lv_b;
    logic [7:0] din_a, din_b;
    logic       rdy_a, sdata_a, sframe_a, done_a, busy_a;
    logic       rdy_b, sdata_b, sframe_b, done_b, busy_b;

    int checks = 0;
    int errors = 0;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv_a),
        .data_in    (din_a),
        .load_ready (rdy_a),
        .sdata      (sdata_a),
        .sframe     (sframe_a),
        .done       (done_a),
        .busy       (busy_a)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv_b),
        .data_in    (din_b),
        .load_ready (rdy_b),
        .sdata      (sdata_b),
        .sframe     (sframe_b),
        .done       (done_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_sdata"},  32'(sdata_a),  32'd0);
        chk({tag, "_sframe"}, 32'(sframe_a), 32'd0);
        chk({tag, "_done"},   32'(done_a),   32'd0);
        chk({tag, "_busy"},   32'(busy_a),   32'd0);
        chk({tag, "_ready"},  32'(rdy_a),    32'd1);
    endtask

    // Caller has already had the word accepted and dropped load_valid; we are in bit 0.
    task automatic send_chk(input logic [7:0] w, input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_sdata"},  32'(sdata_a),  32'(w[7-k]));
            chk({tag, "_sframe"}, 32'(sframe_a), 32'd1);
            chk({tag, "_busy"},   32'(busy_a),   32'd1);
            chk({tag, "_done"},   32'(done_a),   32'(k == 7));
            chk({tag, "_ready"},  32'(rdy_a),    32'(k == 7));
            @(negedge clk);
        end
        chk_idle_a({tag, "_after"});
    endtask

    initial begin
        rst   = 1'b1;
        lv_a  = 1'b0;
        lv_b  = 1'b0;
        din_a = 8'h00;
        din_b = 8'h00;
        @(negedge clk);
        chk_idle_a("reset");

        // Reset wins over a simultaneous load
        lv_a  = 1'b1;
        din_a = 8'hFF;
        @(negedge clk);
        chk_idle_a("rst_vs_load");
        rst  = 1'b0;
        lv_a = 1'b0;
        @(negedge clk);
        chk_idle_a("post_rst");

        // Single word A5, MSB first
        lv_a  = 1'b1;
        din_a = 8'hA5;
        @(negedge clk);
        lv_a = 1'b0;
        send_chk(8'hA5, "a5");

        // Back-to-back FF then 00 with load_valid held high
        lv_a  = 1'b1;
        din_a = 8'hFF;
        @(negedge clk);
        din_a = 8'h00;
        for (int k = 0; k < 16; k++) begin
            chk("b2b_sdata",  32'(sdata_a),  32'(k < 8));
            chk("b2b_sframe", 32'(sframe_a), 32'd1);
            chk("b2b_done",   32'(done_a),   32'((k % 8) == 7));
            chk("b2b_ready",  32'(rdy_a),    32'((k % 8) == 7));
            if (k == 8) lv_a = 1'b0;
            @(negedge clk);
        end
        chk_idle_a("b2b_after");

        // Backpressure: data_in wanders while not ready; 77 is taken at the last bit
        lv_a  = 1'b1;
        din_a = 8'h3C;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("bp_sdata", 32'(sdata_a), 32'(((8'h3C) >> (7 - k)) & 8'h01));
            chk("bp_ready", 32'(rdy_a),   32'(k == 7));
            chk("bp_done",  32'(done_a),  32'(k == 7));
            if (k < 7) din_a = 8'(8'h11 * (k + 1));
            @(negedge clk);
        end
        lv_a = 1'b0;
        send_chk(8'h77, "bp_next");

        // Reset mid-word after bit 3 of F0
        lv_a  = 1'b1;
        din_a = 8'hF0;
        @(negedge clk);
        lv_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_sdata",  32'(sdata_a),  32'd1);
            chk("mid_sframe", 32'(sframe_a), 32'd1);
            if (k == 3) rst = 1'b1;
            @(negedge clk);
        end
        chk_idle_a("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_a("mid_quiet");
        lv_a  = 1'b1;
        din_a = 8'h81;
        @(negedge clk);
        lv_a = 1'b0;
        send_chk(8'h81, "w81");

        // LSB-first instance, word 01
        lv_b  = 1'b1;
        din_b = 8'h01;
        @(negedge clk);
        lv_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("lsb_sdata",  32'(sdata_b),  32'(k == 0));
            chk("lsb_sframe", 32'(sframe_b), 32'd1);
            chk("lsb_busy",   32'(busy_b),   32'd1);
            chk("lsb_done",   32'(done_b),   32'(k == 7));
            chk("lsb_ready",  32'(rdy_b),    32'(k == 7));
            @(negedge clk);
        end
        chk("lsb_after_sframe", 32'(sframe_b), 32'd0);
        chk("lsb_after_busy",   32'(busy_b),   32'd0);
        chk("lsb_after_sdata",  32'(sdata_b),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: word length in bits; legal range 2..32.
REQ-002 The block SHALL take parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 Port clk, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port load_valid, input, 1 bit: data_in holds a word to send.
REQ-006 Port data_in, input, WIDTH bits: parallel word; sampled only on an accepted load.
REQ-007 Port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 Port sdata, output, 1 bit: registered serial data.
REQ-009 Port sframe, output, 1 bit: registered; high on every cycle where sdata carries a valid bit.
REQ-010 Port done, output, 1 bit: registered; one-cycle pulse on the cycle the last bit of a word is on sdata.
REQ-011 Port busy, output, 1 bit: registered; high whenever the FSM is in SHIFT.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-013 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-014 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when the bit counter equals WIDTH-1; 0 otherwise.
REQ-015 On acceptance, the block SHALL copy data_in into a WIDTH-bit shift register, clear the bit counter to 0, and enter or remain in SHIFT.
REQ-016 Latency: for a word accepted at edge N, sdata SHALL present bit k during the cycle after edge N+k, for k=0..WIDTH-1. The first bit appears one cycle after acceptance.
REQ-017 Bit order SHALL be MSB first when MSB_FIRST=1 and LSB first when MSB_FIRST=0.
REQ-018 sframe and busy SHALL be 1 for exactly WIDTH consecutive cycles per word.
REQ-019 done SHALL be 1 only on the cycle carrying bit WIDTH-1 of a word.
REQ-020 In SHIFT, the counter SHALL increment by 1 per cycle; its width SHALL be clog2(WIDTH) bits.
REQ-021 Counter = WIDTH-1 with no accepted load: the next state SHALL be IDLE, and sframe, busy and sdata SHALL go to 0 on the following cycle.
REQ-022 Counter = WIDTH-1 with a load accepted: the block SHALL stay in SHIFT, and bit 0 of the new word SHALL follow the old word's last bit with no gap; sframe SHALL stay high.
REQ-023 In IDLE, sdata SHALL be held at 0.
REQ-024 Changes on data_in or load_valid while load_ready=0 SHALL have no effect.

Reset
REQ-025 When rst=1 at a rising edge, the FSM SHALL go to IDLE; counter, shift register, sdata, sframe, done and busy SHALL all be 0.
REQ-026 With rst=1 and the FSM in IDLE, load_ready SHALL read 1; rst SHALL take priority over any simultaneous load.
REQ-027 Reset mid-word SHALL abort the word with no further bits emitted; the next accepted word SHALL start cleanly from bit 0.

Verification
REQ-028 Single word, WIDTH=8, MSB_FIRST=1, data_in=8'hA5, one-cycle load_valid: sdata = 1,0,1,0,0,1,0,1; sframe high for 8 cycles; done on the 8th; IDLE afterwards.
REQ-029 LSB first, MSB_FIRST=0, data_in=8'h01: sdata = 1 then seven 0s.
REQ-030 Back-to-back, load_valid held high with 8'hFF then 8'h00: sframe high for 16 contiguous cycles; sdata = eight 1s then eight 0s; done pulses on cycles 8 and 16.
REQ-031 Backpressure, load_valid=1 during bits 0..6 with changing data_in: load_ready=0 throughout; the word on the wire is unchanged; acceptance occurs only at counter=7.
REQ-032 Reset mid-word, rst=1 asserted after bit 3 of 8'hF0: the next cycle has sframe=0, sdata=0, busy=0; a subsequent 8'h81 is sent intact as 1,0,0,0,0,0,0,1.
REQ-033 Simultaneous rst=1 and load_valid=1 in IDLE: no word is accepted; all outputs stay 0 the next cycle.
